mips_mc_controller: RTL and testbench
=====================================

// Module: mips_mc_controller
// PURPOSE
//  Multicycle control FSM that sequences the shared 32-bit ALU, memory, IR, PC and register file of the MIPS core.
//  Decodes opcode/funct and drives mux selects, write strobes and the 3-bit ALU control code each cycle.
//  Sits beside the datapath; the only datapath feedback it uses is the ALU zero flag.
// PARAMETERS
//  MEM_WAIT  0  extra stall cycles added to FETCH, MEMRD and MEMWR for slow memory (0..15)
// PORTS
//  clk         in   1  single clock; all state updates on the rising edge
//  reset       in   1  synchronous, active-high
//  opcode      in   6  instr[31:26] from IR
//  funct       in   6  instr[5:0] from IR
//  zero        in   1  ALU flag; 1 when ALU result == 0
//  iord        out  1  memory address select: 0 = PC, 1 = ALUOut
//  memwrite    out  1  data memory write strobe
//  irwrite     out  1  IR load strobe
//  regdst      out  1  write register select: 0 = rt, 1 = rd
//  memtoreg    out  1  write data select: 0 = ALUOut, 1 = memory data
//  regwrite    out  1  register file write strobe
//  alusrca     out  1  ALU A select: 0 = PC, 1 = reg A
//  alusrcb     out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
//  pcsrc       out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  pcen        out  1  PC load enable = pcwrite | (branch & zero)
//  alucontrol  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  state       out  4  current FSM state (debug)
// BEHAVIOUR
//  - Moore outputs decoded from state. All unlisted outputs are 0; alucontrol defaults to 010.
//  - Reset: state <= FETCH and wait counter <= 0 on the next edge, including mid-instruction.
//    While reset is high, pcen, irwrite, memwrite and regwrite are forced to 0.
//  - FETCH: iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00. irwrite and pcwrite assert only in the final wait cycle. -> DECODE
//  - DECODE: alusrca=0, alusrcb=11, ADD. Branch on opcode:
//      lw(100011)/sw(101011) -> MEMADR; R(000000) -> EXECUTE; beq(000100) -> BEQ; j(000010) -> JUMP; other -> FETCH (NOP)
//  - MEMADR: alusrca=1, alusrcb=10, ADD. -> MEMRD if lw, MEMWR if sw.
//  - MEMRD: iord=1. Held MEM_WAIT+1 cycles. -> MEMWB
//  - MEMWB: regdst=0, memtoreg=1, regwrite=1. -> FETCH
//  - MEMWR: iord=1, memwrite=1 on every one of its MEM_WAIT+1 cycles. -> FETCH
//  - EXECUTE: alusrca=1, alusrcb=00; alucontrol from funct:
//      100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, other AND. -> ALUWB
//  - ALUWB: regdst=1, memtoreg=0, regwrite=1. -> FETCH
//  - BEQ: alusrca=1, alusrcb=00, SUB, pcsrc=01, branch=1. pcen = zero. -> FETCH
//  - JUMP: pcsrc=10, pcwrite=1. -> FETCH
//  - Wait counter: 4-bit; loads 0 on entry to a wait state and increments each cycle. The state advances when count == MEM_WAIT.
//    Outputs are held constant across all wait cycles.
//  - Latency with MEM_WAIT = W: lw 5+2W, sw 4+2W, R 4+W, beq 3+W, j 3+W cycles.
// CONFIGURATION
//  MIPS_MC_ADDI_EN defined:
//    - DECODE routes addi(001000) -> ADDIEX (alusrca=1, alusrcb=10, ADD) -> ADDIWB (regdst=0, memtoreg=0, regwrite=1) -> FETCH.
//    - addi takes 4+W cycles.
//  MIPS_MC_ADDI_EN undefined:
//    - opcode 001000 is illegal; DECODE -> FETCH, no writes.
//    - ADDIEX/ADDIWB encodings are reserved; they are unreachable and fall back to FETCH.
// STRUCTURE
//  - Package mips_pkg holds: opcode and funct constants, ALU control codes, the state encoding (4-bit), and ALUSRCB/PCSRC select constants.
//  - Sub-module alu_decoder (aluop[1:0], funct -> alucontrol):
//      aluop 00 = ADD, 01 = SUB, 10 = decode funct.
//  - The FSM drives aluop per state.
// TESTING
//  1. reset held 2 cycles mid-lw (in MEMRD) -> state=FETCH next edge; pcen/irwrite/regwrite = 0 while reset is high.
//  2. MEM_WAIT=0, lw -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
//  3. MEM_WAIT=2, sw -> 8 cycles total; memwrite=1 for exactly 3 consecutive cycles; irwrite once, in FETCH cycle 3.
//  4. R-type with funct 100010, then 101010 -> alucontrol 110 then 111 in EXECUTE; ALUWB has regdst=1.
//  5. beq with zero=1 -> pcen=1, pcsrc=01 in BEQ; with zero=0 -> pcen=0; then back to FETCH.
//  6. opcode 001000: with MIPS_MC_ADDI_EN -> ADDIWB regwrite=1 after 4 cycles; without it -> DECODE->FETCH, no regwrite.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcode/funct
// values, ALU control codes, select encodings, FSM state encoding and the
// bundle of registered control outputs.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// The controller side (master) reads instruction fields and the zero flag
// and drives every select and strobe; the datapath side (slave) mirrors it.
interface mips_mc_controller_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, state
  );

  modport slave (
    output opcode, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, state
  );

endinterface

// File: rtl/alu_decoder.sv
// Translates the FSM's coarse ALU request plus the R-type funct field into
// the 3-bit ALU control code. Unknown funct values fall back to AND.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Pick the ALU operation; only aluop=10 looks at funct
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM. Moore outputs are registered alongside the
// state; FETCH, MEMRD and MEMWR are stretched by MEM_WAIT extra cycles.
// Optional addi support is enabled by defining MIPS_MC_ADDI_EN.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int MEM_WAIT = 0
)
(
  input logic             clk,
  input logic             reset,
  mips_mc_controller_if.master bus
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] alucontrol;

  // Moore output decode for a given state and wait-counter value
  function automatic ctrl_t decode_outputs(state_t s, logic [3:0] cnt);
    ctrl_t c;
    c = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.alusrcb = SRCB_FOUR;
        c.pcsrc   = PCSRC_ALU;
        c.irwrite = (cnt == WAIT_LAST);
        c.pcwrite = (cnt == WAIT_LAST);
      end
      S_DECODE:  c.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REGB;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REGB;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.branch  = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
`endif
      default: c.aluop = ALUOP_ADD;
    endcase
    return c;
  endfunction

  // Next state, wait counter and the outputs that go with them
  always_comb begin
    state_d = state_q;
    count_d = 4'd0;
    case (state_q)
      S_FETCH: begin
        if (count_q == WAIT_LAST) state_d = S_DECODE;
        else                      count_d = count_q + 4'd1;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW)      state_d = S_MEMRD;
        else if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_FETCH;
      end
      S_MEMRD: begin
        if (count_q == WAIT_LAST) state_d = S_MEMWB;
        else                      count_d = count_q + 4'd1;
      end
      S_MEMWR: begin
        if (count_q == WAIT_LAST) state_d = S_FETCH;
        else                      count_d = count_q + 4'd1;
      end
      S_EXECUTE: state_d = S_ALUWB;
`ifdef MIPS_MC_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
    ctrl_d = decode_outputs(state_d, count_d);
  end

  // State, counter and registered outputs; reset restarts at FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= 4'd0;
      ctrl_q  <= decode_outputs(S_FETCH, 4'd0);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctrl_q.aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol)
  );

  assign bus.iord       = ctrl_q.iord;
  assign bus.regdst     = ctrl_q.regdst;
  assign bus.memtoreg   = ctrl_q.memtoreg;
  assign bus.alusrca    = ctrl_q.alusrca;
  assign bus.alusrcb    = ctrl_q.alusrcb;
  assign bus.pcsrc      = ctrl_q.pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;
  assign bus.memwrite   = ctrl_q.memwrite & ~reset;
  assign bus.irwrite    = ctrl_q.irwrite & ~reset;
  assign bus.regwrite   = ctrl_q.regwrite & ~reset;
  assign bus.pcen       = (ctrl_q.pcwrite | (ctrl_q.branch & bus.zero)) & ~reset;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: two instances (MEM_WAIT 0 and 2) compared
// cycle by cycle against a phase-sequence model of each instruction.
module tb_mips_mc_controller;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mips_mc_controller_if if0 ();
  mips_mc_controller_if if2 ();

  mips_mc_controller #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  mips_mc_controller #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.master));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
  } obs_t;

  localparam int P_END = 0, P_F = 1, P_D = 2, P_MA = 3, P_MR = 4, P_MWB = 5, P_MW = 6;
  localparam int P_EX = 7, P_AWB = 8, P_BQ = 9, P_J = 10, P_AX = 11, P_AXWB = 12;

  // Which phase an instruction is in at cycle k (0 = first FETCH cycle)
  function automatic int phase_at(logic [5:0] op, int w, int k);
    int r;
    r = k;
    if (r <= w) return P_F;
    r = r - (w + 1);
    if (r == 0) return P_D;
    r = r - 1;
    case (op)
      6'b100011: return (r == 0) ? P_MA : (r <= w + 1) ? P_MR : (r == w + 2) ? P_MWB : P_END;
      6'b101011: return (r == 0) ? P_MA : (r <= w + 1) ? P_MW : P_END;
      6'b000000: return (r == 0) ? P_EX : (r == 1) ? P_AWB : P_END;
      6'b000100: return (r == 0) ? P_BQ : P_END;
      6'b000010: return (r == 0) ? P_J : P_END;
`ifdef MIPS_MC_ADDI_EN
      6'b001000: return (r == 0) ? P_AX : (r == 1) ? P_AXWB : P_END;
`endif
      default:   return P_END;
    endcase
  endfunction

  function automatic int latency(logic [5:0] op, int w);
    int n;
    n = 0;
    while (phase_at(op, w, n) != P_END && n < 64) n++;
    return n;
  endfunction

  // Expected outputs for one phase, straight from the per-state table
  function automatic obs_t expect_obs(int tag, logic [5:0] fn, logic z, bit last);
    obs_t e;
    e = '0;
    e.alucontrol = 3'b010;
    case (tag)
      P_F:   begin e.state = S_FETCH; e.alusrcb = 2'b01; e.irwrite = last; e.pcen = last; end
      P_D:   begin e.state = S_DECODE; e.alusrcb = 2'b11; end
      P_MA:  begin e.state = S_MEMADR; e.alusrca = 1; e.alusrcb = 2'b10; end
      P_MR:  begin e.state = S_MEMRD; e.iord = 1; end
      P_MWB: begin e.state = S_MEMWB; e.memtoreg = 1; e.regwrite = 1; end
      P_MW:  begin e.state = S_MEMWR; e.iord = 1; e.memwrite = 1; end
      P_EX: begin
        e.state = S_EXECUTE; e.alusrca = 1;
        case (fn)
          6'b100000: e.alucontrol = 3'b010;
          6'b100010: e.alucontrol = 3'b110;
          6'b100101: e.alucontrol = 3'b001;
          6'b101010: e.alucontrol = 3'b111;
          default:   e.alucontrol = 3'b000;
        endcase
      end
      P_AWB: begin e.state = S_ALUWB; e.regdst = 1; e.regwrite = 1; end
      P_BQ:  begin e.state = S_BEQ; e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      P_J:   begin e.state = S_JUMP; e.pcsrc = 2'b10; e.pcen = 1; end
      P_AX:  begin e.state = S_ADDIEX; e.alusrca = 1; e.alusrcb = 2'b10; end
      P_AXWB: begin e.state = S_ADDIWB; e.regwrite = 1; end
      default: e.state = 4'hF;
    endcase
    return e;
  endfunction

  function automatic obs_t obs(int which);
    obs_t o;
    if (which == 0)
      o = {if0.state, if0.iord, if0.memwrite, if0.irwrite, if0.regdst, if0.memtoreg, if0.regwrite,
           if0.alusrca, if0.alusrcb, if0.pcsrc, if0.pcen, if0.alucontrol};
    else
      o = {if2.state, if2.iord, if2.memwrite, if2.irwrite, if2.regdst, if2.memtoreg, if2.regwrite,
           if2.alusrca, if2.alusrcb, if2.pcsrc, if2.pcen, if2.alucontrol};
    return o;
  endfunction

  task automatic drive(int which, logic [5:0] op, logic [5:0] fn, logic z);
    if (which == 0) begin if0.opcode = op; if0.funct = fn; if0.zero = z; end
    else begin if2.opcode = op; if2.funct = fn; if2.zero = z; end
  endtask

  // Both instances back to FETCH; leaves time at posedge+1 with reset low
  task automatic do_reset();
    drive(0, 6'b111111, 6'h00, 1'b0);
    drive(2, 6'b111111, 6'h00, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset();
    drive(0, 6'b100011, 6'h00, 1'b0);
    drive(2, 6'b100011, 6'h00, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (if2.state !== S_MEMRD) begin failures++; $display("[TB] FAIL rst_pre_state: got %0d expected %0d", if2.state, S_MEMRD); end
    reset = 1'b1;
    #1;
    checks++; if ({if0.pcen, if0.irwrite, if2.regwrite} !== 3'b000) begin failures++; $display("[TB] FAIL rst_gate_a: got %b expected 000", {if0.pcen, if0.irwrite, if2.regwrite}); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++; if (if2.state !== S_FETCH) begin failures++; $display("[TB] FAIL rst_state%0d: got %0d expected %0d", c, if2.state, S_FETCH); end
      checks++; if ({if0.pcen, if0.irwrite, if0.regwrite, if0.memwrite} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_gate%0d: got %b expected 0000", c, {if0.pcen, if0.irwrite, if0.regwrite, if0.memwrite}); end
    end
    reset = 1'b0;
    #1;
    o = obs(0);
    checks++; if (o !== expect_obs(P_F, 6'h00, 1'b0, 1'b1)) begin failures++; $display("[TB] FAIL rst_release0: got %h expected %h", o, expect_obs(P_F, 6'h00, 1'b0, 1'b1)); end
    o = obs(2);
    checks++; if (o !== expect_obs(P_F, 6'h00, 1'b0, 1'b0)) begin failures++; $display("[TB] FAIL rst_release2: got %h expected %h", o, expect_obs(P_F, 6'h00, 1'b0, 1'b0)); end
    // Reset landing on MEMWB (regwrite) and MEMWR (memwrite) of the W=0 instance
    for (int t = 0; t < 2; t++) begin
      do_reset();
      drive(0, (t == 0) ? 6'b100011 : 6'b101011, 6'h00, 1'b0);
      repeat ((t == 0) ? 4 : 3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++; if ({if0.regwrite, if0.memwrite} !== 2'b00) begin failures++; $display("[TB] FAIL rst_strobe%0d: got %b expected 00", t, {if0.regwrite, if0.memwrite}); end
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (if0.state !== S_FETCH) begin failures++; $display("[TB] FAIL rst_mid%0d: got %0d expected %0d", t, if0.state, S_FETCH); end
    end
  endtask

  task automatic test_lw();
    obs_t o, e;
    logic [4:0] rw, mt;
    int n;
    rw = '0; mt = '0;
    do_reset();
    drive(0, 6'b100011, 6'h15, 1'b0);
    #1;
    n = latency(6'b100011, 0);
    for (int k = 0; k < n; k++) begin
      o = obs(0);
      e = expect_obs(phase_at(6'b100011, 0, k), 6'h15, 1'b0, k == 0);
      checks++; if (o !== e) begin failures++; $display("[TB] FAIL lw_cyc%0d: got %h expected %h", k, o, e); end
      if (k < 5) begin rw[k] = o.regwrite; mt[k] = o.memtoreg; end
      @(posedge clk); #1;
    end
    checks++; if ({rw, mt} !== 10'b10000_10000) begin failures++; $display("[TB] FAIL lw_wb_only_c5: got %b expected 1000010000", {rw, mt}); end
  endtask

  task automatic test_sw_wait();
    obs_t o, e;
    logic [7:0] mw, ir;
    mw = '0; ir = '0;
    do_reset();
    drive(2, 6'b101011, 6'h00, 1'b1);
    #1;
    for (int k = 0; k < 8; k++) begin
      o = obs(2);
      e = expect_obs(phase_at(6'b101011, 2, k), 6'h00, 1'b1, k == 2);
      checks++; if (o !== e) begin failures++; $display("[TB] FAIL sw_cyc%0d: got %h expected %h", k, o, e); end
      mw[k] = o.memwrite; ir[k] = o.irwrite;
      @(posedge clk); #1;
    end
    checks++; if ({mw, ir} !== 16'b11100000_00000100) begin failures++; $display("[TB] FAIL sw_strobes: got %b expected 1110000000000100", {mw, ir}); end
    checks++; if (if2.state !== S_FETCH) begin failures++; $display("[TB] FAIL sw_done: got %0d expected %0d", if2.state, S_FETCH); end
  endtask

  task automatic test_rtype();
    obs_t o, e;
    logic [5:0] fns [2];
    logic [2:0] want [2];
    fns = '{6'b100010, 6'b101010};
    want = '{3'b110, 3'b111};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 6'b000000, fns[i], 1'b0);
      #1;
      for (int k = 0; k < 4; k++) begin
        o = obs(0);
        e = expect_obs(phase_at(6'b000000, 0, k), fns[i], 1'b0, k == 0);
        checks++; if (o !== e) begin failures++; $display("[TB] FAIL r%0d_cyc%0d: got %h expected %h", i, k, o, e); end
        if (k == 2) begin checks++; if (o.alucontrol !== want[i]) begin failures++; $display("[TB] FAIL r%0d_alu: got %b expected %b", i, o.alucontrol, want[i]); end end
        if (k == 3) begin checks++; if (o.regdst !== 1'b1) begin failures++; $display("[TB] FAIL r%0d_regdst: got %b expected 1", i, o.regdst); end end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_beq();
    obs_t o, e;
    do_reset();
    for (int z = 1; z >= 0; z--) begin
      drive(2, 6'b000100, 6'h00, z[0]);
      #1;
      for (int k = 0; k < 5; k++) begin
        o = obs(2);
        e = expect_obs(phase_at(6'b000100, 2, k), 6'h00, z[0], k == 2);
        checks++; if (o !== e) begin failures++; $display("[TB] FAIL beq_z%0d_cyc%0d: got %h expected %h", z, k, o, e); end
        if (k == 4) begin checks++; if ({o.pcen, o.pcsrc} !== {z[0], 2'b01}) begin failures++; $display("[TB] FAIL beq_z%0d_pc: got %b expected %b", z, {o.pcen, o.pcsrc}, {z[0], 2'b01}); end end
        @(posedge clk); #1;
      end
      checks++; if (if2.state !== S_FETCH) begin failures++; $display("[TB] FAIL beq_z%0d_ret: got %0d expected %0d", z, if2.state, S_FETCH); end
    end
  endtask

  task automatic test_addi();
    obs_t o, e;
    logic [3:0] rw;
    int n;
    rw = '0;
    do_reset();
    drive(0, 6'b001000, 6'h00, 1'b0);
    #1;
    n = latency(6'b001000, 0);
    for (int k = 0; k < n + 1; k++) begin
      o = obs(0);
      e = (k < n) ? expect_obs(phase_at(6'b001000, 0, k), 6'h00, 1'b0, k == 0) : expect_obs(P_F, 6'h00, 1'b0, 1'b1);
      checks++; if (o !== e) begin failures++; $display("[TB] FAIL addi_cyc%0d: got %h expected %h", k, o, e); end
      if (k < 4) rw[k] = o.regwrite;
      @(posedge clk); #1;
    end
`ifdef MIPS_MC_ADDI_EN
    checks++; if (rw !== 4'b1000) begin failures++; $display("[TB] FAIL addi_wb: got %b expected 1000", rw); end
`else
    checks++; if (rw !== 4'b0000) begin failures++; $display("[TB] FAIL addi_nowb: got %b expected 0000", rw); end
`endif
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [5:0] ops [8];
    logic [5:0] fnl [6];
    logic [5:0] op, fn;
    logic z;
    int w, n;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b001101};
    fnl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int which = 0; which <= 2; which += 2) begin
      w = which;
      do_reset();
      for (int i = 0; i < 40; i++) begin
        op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
        fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fnl[$urandom_range(0, 5)];
        z = 1'($urandom_range(0, 1));
        drive(which, op, fn, z);
        #1;
        n = latency(op, w);
        for (int k = 0; k < n; k++) begin
          o = obs(which);
          e = expect_obs(phase_at(op, w, k), fn, z, k == w);
          checks++; if (o !== e) begin failures++; $display("[TB] FAIL rand_w%0d_i%0d_op%b_cyc%0d: got %h expected %h", w, i, op, k, o, e); end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_beq();
    test_addi();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
